// File: rtl/cam_cmd_tracker.sv
// Write-side manager for the command CAM: allocates free slots and deletes entries found by lookup.
// Optional duplicate rejection on alloc is enabled by defining CAM_TRACK_DUP_CHECK_EN.
module cam_cmd_tracker #(
  parameter int PROC_COUNT = 4,
  parameter int CMD_WIDTH  = 4,
  parameter int PID_W      = $clog2(PROC_COUNT),
  parameter int DATA_WIDTH = CMD_WIDTH + PID_W,
  parameter int ADDR_WIDTH = PID_W + 1,
  parameter int LOOKUP_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [CMD_WIDTH-1:0]  alloc_cmd_id,
  input  logic [PID_W-1:0]      alloc_proc_id,
  output logic                  alloc_done,
  output logic                  alloc_err,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  rel_valid,
  output logic                  rel_ready,
  input  logic [CMD_WIDTH-1:0]  rel_cmd_id,
  input  logic [PID_W-1:0]      rel_proc_id,
  input  logic [1:0]            rel_mask,
  output logic                  rel_done,
  output logic                  rel_hit,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  output logic [1:0]            cam_select_mask,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

`ifdef CAM_TRACK_DUP_CHECK_EN
  localparam logic DUP_EN = 1'b1;
`else
  localparam logic DUP_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_WR_ISSUE = 3'd2;
  localparam logic [2:0] S_WR_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  is_rel_q, is_rel_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [1:0]            mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  del_q, del_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      lk_cnt_q, lk_cnt_d;
  logic                  wait_first_q, wait_first_d;
  logic [DEPTH-1:0]      free_q, free_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] free_idx;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_q[i]) free_idx = ADDR_WIDTH'(i);
    end
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    is_rel_d     = is_rel_q;
    key_d        = key_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    del_d        = del_q;
    hit_d        = hit_q;
    err_d        = err_q;
    lk_cnt_d     = lk_cnt_q;
    wait_first_d = wait_first_q;
    free_d       = free_q;
    count_d      = count_q;
    case (state_q)
      S_IDLE: begin
        if (rel_valid) begin
          is_rel_d = 1'b1;
          key_d    = {rel_cmd_id, rel_proc_id};
          mask_d   = rel_mask;
          hit_d    = 1'b0;
          err_d    = 1'b0;
          lk_cnt_d = '0;
          state_d  = (rel_mask == 2'b00) ? S_DONE : S_LOOKUP;
        end else if (alloc_valid && !full) begin
          is_rel_d = 1'b0;
          key_d    = {alloc_cmd_id, alloc_proc_id};
          addr_d   = free_idx;
          del_d    = 1'b0;
          hit_d    = 1'b0;
          err_d    = 1'b0;
          lk_cnt_d = '0;
          if (DUP_EN) begin
            mask_d  = 2'b11;
            state_d = S_LOOKUP;
          end else begin
            state_d = S_WR_ISSUE;
          end
        end
      end
      S_LOOKUP: begin
        if (lk_cnt_q == CNT_W'(LOOKUP_LAT - 1)) begin
          if (cam_match) begin
            addr_d = cam_match_addr;
            if (is_rel_q) begin
              hit_d   = 1'b1;
              del_d   = 1'b1;
              state_d = S_WR_ISSUE;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            state_d = is_rel_q ? S_DONE : S_WR_ISSUE;
          end
        end else begin
          lk_cnt_d = lk_cnt_q + CNT_W'(1);
        end
      end
      S_WR_ISSUE: begin
        wait_first_d = 1'b1;
        state_d      = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        // The CAM may raise busy one cycle after the enable, so the first cycle is not trusted.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (!cam_write_busy) begin
          if (del_q) begin
            free_d[addr_q] = 1'b1;
            if (!free_q[addr_q]) count_d = count_q - (ADDR_WIDTH + 1)'(1);
          end else begin
            free_d[addr_q] = 1'b0;
            if (free_q[addr_q]) count_d = count_q + (ADDR_WIDTH + 1)'(1);
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the free bitmap is a handful of flops, not a RAM, so it is reset along with the CAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_rel_q     <= 1'b0;
      key_q        <= '0;
      mask_q       <= 2'b00;
      addr_q       <= '0;
      del_q        <= 1'b0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      lk_cnt_q     <= '0;
      wait_first_q <= 1'b0;
      free_q       <= '1;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      is_rel_q     <= is_rel_d;
      key_q        <= key_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      del_q        <= del_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
      lk_cnt_q     <= lk_cnt_d;
      wait_first_q <= wait_first_d;
      free_q       <= free_d;
      count_q      <= count_d;
    end
  end

  assign count            = count_q;
  assign full             = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty            = (count_q == '0);
  assign rel_ready        = (state_q == S_IDLE);
  assign alloc_ready      = (state_q == S_IDLE) && !full && !rel_valid;
  assign alloc_done       = (state_q == S_DONE) && !is_rel_q;
  assign rel_done         = (state_q == S_DONE) && is_rel_q;
  assign alloc_err        = alloc_done && err_q;
  assign rel_hit          = rel_done && hit_q;
  assign alloc_addr       = addr_q;
  assign cam_write_enable = (state_q == S_WR_ISSUE);
  assign cam_write_addr   = addr_q;
  assign cam_write_data   = key_q;
  assign cam_write_delete = del_q;
  assign cam_compare_data = key_q;
  assign cam_select_mask  = mask_q;

endmodule

// File: tb/tb_cam_cmd_tracker.sv
// Scoreboard bench for cam_cmd_tracker with a behavioural CAM (compare port, write port, busy).
// Expected done results are queued at stimulus time and popped on each done pulse.
module tb_cam_cmd_tracker;

  localparam int CMD_W = 4;
  localparam int PID_W = 2;
  localparam int DW    = CMD_W + PID_W;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int LAT   = 2;
`ifdef CAM_TRACK_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             alloc_valid, alloc_ready, alloc_done, alloc_err;
  logic [CMD_W-1:0] alloc_cmd_id, rel_cmd_id;
  logic [PID_W-1:0] alloc_proc_id, rel_proc_id;
  logic [AW-1:0]    alloc_addr, cam_write_addr, cam_match_addr;
  logic             rel_valid, rel_ready, rel_done, rel_hit;
  logic [1:0]       rel_mask, cam_select_mask;
  logic [AW:0]      count;
  logic             full, empty;
  logic [DW-1:0]    cam_write_data, cam_compare_data;
  logic             cam_write_delete, cam_write_enable, cam_write_busy, cam_match;

  cam_cmd_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_cmd_id(alloc_cmd_id), .alloc_proc_id(alloc_proc_id),
    .alloc_done(alloc_done), .alloc_err(alloc_err), .alloc_addr(alloc_addr),
    .rel_valid(rel_valid), .rel_ready(rel_ready),
    .rel_cmd_id(rel_cmd_id), .rel_proc_id(rel_proc_id), .rel_mask(rel_mask),
    .rel_done(rel_done), .rel_hit(rel_hit),
    .count(count), .full(full), .empty(empty),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy),
    .cam_compare_data(cam_compare_data), .cam_select_mask(cam_select_mask),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  // Behavioural CAM, cleared by the same reset as the tracker.
  logic [DW-1:0]    cam_mem [DEPTH];
  logic [DEPTH-1:0] cam_vld;
  int               busy_len = 0;
  int               busy_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vld   <= '0;
      busy_left <= 0;
    end else if (cam_write_enable) begin
      cam_vld[cam_write_addr] <= !cam_write_delete;
      cam_mem[cam_write_addr] <= cam_write_data;
      busy_left               <= busy_len;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end
  assign cam_write_busy = (busy_left != 0);

  always_comb begin
    cam_match      = 1'b0;
    cam_match_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cam_vld[i]
          && (!cam_select_mask[1] || cam_mem[i][DW-1:PID_W] == cam_compare_data[DW-1:PID_W])
          && (!cam_select_mask[0] || cam_mem[i][PID_W-1:0] == cam_compare_data[PID_W-1:0])) begin
        cam_match      = 1'b1;
        cam_match_addr = AW'(i);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_rel;
    bit          flag;
    logic [AW-1:0] addr;
    int          wr;
    bit          del;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  bit            ref_vld [DEPTH];
  logic [DW-1:0] ref_data [DEPTH];
  int            ref_count = 0;

  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc_log[$];
  int            en_cnt = 0;
  logic [AW-1:0] w_addr;
  logic          w_del;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cam_write_enable) begin
      en_cnt++;
      w_addr = cam_write_addr;
      w_del  = cam_write_delete;
    end
    if (alloc_done || rel_done) begin
      done_cnt++;
      done_cyc_log.push_back(cyc);
      check("done_onehot", alloc_done & rel_done, 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_kind_rel", rel_done, e.is_rel);
        if (e.is_rel) begin
          check("rel_hit", rel_hit, e.flag);
        end else begin
          check("alloc_err", alloc_err, e.flag);
          check("alloc_addr", alloc_addr, e.addr);
        end
        check("wr_enable_cycles", en_cnt, e.wr);
        if (e.wr == 1) begin
          check("wr_addr", w_addr, e.addr);
          check("wr_delete", w_del, e.del);
        end
      end
      en_cnt = 0;
    end
  end

  function automatic int ref_free();
    for (int i = 0; i < DEPTH; i++) if (!ref_vld[i]) return i;
    return 0;
  endfunction

  function automatic int ref_find(input logic [DW-1:0] key, input logic [1:0] mask);
    for (int i = 0; i < DEPTH; i++)
      if (ref_vld[i] && (!mask[1] || ref_data[i][DW-1:PID_W] == key[DW-1:PID_W])
                     && (!mask[0] || ref_data[i][PID_W-1:0] == key[PID_W-1:0])) return i;
    return -1;
  endfunction

  // Pushes the expected done result and returns the expected accept->done latency.
  function automatic int exp_alloc(input logic [CMD_W-1:0] cmd, input logic [PID_W-1:0] pid,
                                   input int busy);
    exp_t x;
    int   hit_i;
    int   free_i;
    int   lat;
    hit_i = DUP ? ref_find({cmd, pid}, 2'b11) : -1;
    if (hit_i >= 0) begin
      x   = '{is_rel: 1'b0, flag: 1'b1, addr: AW'(hit_i), wr: 0, del: 1'b0};
      lat = 1 + LAT;
    end else begin
      free_i = ref_free();
      x      = '{is_rel: 1'b0, flag: 1'b0, addr: AW'(free_i), wr: 1, del: 1'b0};
      ref_vld[free_i]  = 1'b1;
      ref_data[free_i] = {cmd, pid};
      ref_count++;
      lat = (DUP ? 4 + LAT : 4) + ((busy > 1) ? busy - 1 : 0);
    end
    sb.push_back(x);
    return lat;
  endfunction

  function automatic int exp_rel(input logic [CMD_W-1:0] cmd, input logic [PID_W-1:0] pid,
                                 input logic [1:0] mask, input int busy);
    exp_t x;
    int   hit_i;
    int   lat;
    hit_i = (mask == 2'b00) ? -1 : ref_find({cmd, pid}, mask);
    if (hit_i >= 0) begin
      x   = '{is_rel: 1'b1, flag: 1'b1, addr: AW'(hit_i), wr: 1, del: 1'b1};
      ref_vld[hit_i] = 1'b0;
      ref_count--;
      lat = 4 + LAT + ((busy > 1) ? busy - 1 : 0);
    end else begin
      x   = '{is_rel: 1'b1, flag: 1'b0, addr: '0, wr: 0, del: 1'b0};
      lat = (mask == 2'b00) ? 1 : 1 + LAT;
    end
    sb.push_back(x);
    return lat;
  endfunction

  // Called at a negedge with the request already driven; returns the accept cycle.
  task automatic wait_accept(input bit is_rel, output int acc);
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (is_rel ? rel_ready : alloc_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (is_rel) rel_valid = 1'b0;
    else alloc_valid = 1'b0;
    if (acc < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target, input int acc, input int lat, input string tag);
    int i = 0;
    while (done_cnt < target && i < 80) begin
      @(posedge clk);
      i++;
    end
    if (done_cnt < target) check({tag, "_done_timeout"}, 0, 1);
    else check({tag, "_latency"}, done_cyc_log[target-1] - acc, lat);
  endtask

  task automatic check_occ(input string tag);
    #1;
    check({tag, "_count"}, count, ref_count);
    check({tag, "_full"}, full, ref_count == DEPTH);
    check({tag, "_empty"}, empty, ref_count == 0);
  endtask

  task automatic run_alloc(input logic [CMD_W-1:0] cmd, input logic [PID_W-1:0] pid,
                           input int busy, input string tag);
    int lat, acc, start;
    start    = done_cnt;
    lat      = exp_alloc(cmd, pid, busy);
    busy_len = busy;
    @(negedge clk);
    alloc_cmd_id  = cmd;
    alloc_proc_id = pid;
    alloc_valid   = 1'b1;
    wait_accept(1'b0, acc);
    wait_done(start + 1, acc, lat, tag);
    @(negedge clk);
    check_occ(tag);
  endtask

  task automatic run_rel(input logic [CMD_W-1:0] cmd, input logic [PID_W-1:0] pid,
                         input logic [1:0] mask, input int busy, input string tag);
    int lat, acc, start;
    start    = done_cnt;
    lat      = exp_rel(cmd, pid, mask, busy);
    busy_len = busy;
    @(negedge clk);
    rel_cmd_id  = cmd;
    rel_proc_id = pid;
    rel_mask    = mask;
    rel_valid   = 1'b1;
    wait_accept(1'b1, acc);
    wait_done(start + 1, acc, lat, tag);
    @(negedge clk);
    check_occ(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int start, acc_r, acc_a, lat_r, lat_a;
    alloc_valid = 1'b0; alloc_cmd_id = '0; alloc_proc_id = '0;
    rel_valid = 1'b0; rel_cmd_id = '0; rel_proc_id = '0; rel_mask = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      ref_vld[i]  = 1'b0;
      ref_data[i] = '0;
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_pulses", {alloc_done, rel_done, cam_write_enable, cam_write_delete}, 0);
    check("rst_select_mask", cam_select_mask, 0);
    check("rst_compare_data", cam_compare_data, 0);
    check("rst_rel_ready", rel_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_alloc(4'd1, 2'd2, 0, "t1_alloc");
    run_rel(4'd1, 2'd2, 2'b11, 0, "t2_rel_hit");
    run_rel(4'd1, 2'd2, 2'b11, 0, "t2_rel_miss");

    run_alloc(4'd1, 2'd2, 0, "t3_alloc_a");
    run_rel(4'd11, 2'd2, 2'b01, 0, "t3_rel_pid");
    run_alloc(4'd1, 2'd2, 0, "t3_alloc_b");
    run_rel(4'd1, 2'd3, 2'b10, 0, "t3_rel_cmd");
    run_rel(4'd1, 2'd2, 2'b00, 0, "t3_rel_nomask");

    for (int i = 0; i < DEPTH; i++)
      run_alloc(CMD_W'(i + 2), PID_W'(i), 0, "t4_fill");
    check("t4_alloc_ready_full", alloc_ready, 0);
    run_rel(4'd5, 2'd3, 2'b00, 0, "t4_rel_nomask_full");
    run_rel(4'd5, 2'd3, 2'b11, 0, "t4_rel_slot3");
    run_alloc(4'd15, 2'd1, 0, "t4_realloc");

    run_rel(4'd2, 2'd0, 2'b11, 0, "t5_rel_slot0");
    run_alloc(4'd13, 2'd2, 5, "t5_busy_alloc");
    run_rel(4'd4, 2'd2, 2'b11, 5, "t5_busy_rel");

    start    = done_cnt;
    lat_r    = exp_rel(4'd3, 2'd1, 2'b11, 0);
    lat_a    = exp_alloc(4'd14, 2'd0, 0);
    busy_len = 0;
    @(negedge clk);
    rel_cmd_id = 4'd3; rel_proc_id = 2'd1; rel_mask = 2'b11; rel_valid = 1'b1;
    alloc_cmd_id = 4'd14; alloc_proc_id = 2'd0; alloc_valid = 1'b1;
    #1;
    check("t5_alloc_blocked", alloc_ready, 0);
    check("t5_rel_ready", rel_ready, 1);
    wait_accept(1'b1, acc_r);
    wait_accept(1'b0, acc_a);
    wait_done(start + 1, acc_r, lat_r, "t5_prio_rel");
    wait_done(start + 2, acc_a, lat_a, "t5_prio_alloc");
    @(negedge clk);
    check_occ("t5_prio");

    start    = done_cnt;
    busy_len = 0;
    @(negedge clk);
    alloc_cmd_id = 4'd9; alloc_proc_id = 2'd1; alloc_valid = 1'b1;
    wait_accept(1'b0, acc_a);
    while (cyc < acc_a + 1 + (DUP ? LAT : 0)) @(negedge clk);
    #1;
    check("t6_wr_issue_enable", cam_write_enable, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_enable_drop", cam_write_enable, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
    ref_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_done_after_rst", done_cnt, start);
    en_cnt = 0;

    run_alloc(4'd1, 2'd2, 0, "t6_dup_first");
    run_alloc(4'd1, 2'd2, 0, "t6_dup_second");

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
